// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the signals exchanged between the pipeline datapath and the
//   hazard controller.
//   master : pipeline side. Drives the instructions and mem_ready, and
//            receives the stall/bubble controls.
//   slave  : controller side (pipeline_hazard_ctrl).
//   Signals:
//     id_instruction, ex_instruction, mem_instruction [19:0]
//                    : instructions currently in the ID, EX and MEM stages
//     mem_ready      : data memory has completed the current access
//     pc_write, if_id_write, id_ex_write, ex_mem_write
//                    : register load enables
//     id_ex_bubble, mem_wb_bubble
//                    : load a NOP into ID/EX or MEM/WB instead of stage data
//     mem_req        : data-memory access request
//     mem_error      : sticky flag, set when a memory access timed out
//     ctrl_state[1:0]: current controller state
//     stall_cycles   : stall counter; only present when HAZARD_STALL_COUNT_EN
//                      is defined
interface pipeline_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [19:0] id_instruction;
  logic [19:0] ex_instruction;
  logic [19:0] mem_instruction;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        id_ex_bubble;
  logic        ex_mem_write;
  logic        mem_wb_bubble;
  logic        mem_req;
  logic        mem_error;
  logic [1:0]  ctrl_state;
`ifdef HAZARD_STALL_COUNT_EN
  logic [STALL_CNT_W-1:0] stall_cycles;
`endif

  if (STALL_CNT_W < 1) begin : g_bad_stall_cnt_w
    $error("STALL_CNT_W must be at least 1");
  end

  modport master (
    output id_instruction, ex_instruction, mem_instruction, mem_ready,
`ifdef HAZARD_STALL_COUNT_EN
    input  stall_cycles,
`endif
    input  pc_write, if_id_write, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, mem_req, mem_error, ctrl_state
  );

  modport slave (
    input  id_instruction, ex_instruction, mem_instruction, mem_ready,
`ifdef HAZARD_STALL_COUNT_EN
    output stall_cycles,
`endif
    output pc_write, if_id_write, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, mem_req, mem_error, ctrl_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/bubble controller for the 5-stage, 20-bit pipeline.
//   It inserts bubbles on load-use hazards between ID and EX, and it
//   sequences variable-latency data-memory accesses from MEM. While an
//   access is waiting, the upstream stages are frozen and MEM/WB is bubbled.
//   Instruction fields: [19:16] opcode, [15:12] rd, [11:8] rs, [7:4] rt.
//   Ports:
//     clock : system clock, rising edge
//     reset : synchronous, active-low reset
//     bus   : pipeline_hazard_ctrl_if.slave. It carries the instructions,
//             mem_ready, the write enables, the bubbles, mem_req, mem_error,
//             ctrl_state and (optionally) stall_cycles.
//   Optional feature macro: HAZARD_STALL_COUNT_EN. When it is defined, the
//   design adds a saturating counter of cycles with pc_write = 0.
//   STALL_CNT_W must match the width the interface was built with.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int WAIT_TIMEOUT    = 15,
  parameter int STALL_CNT_W     = 16
) (
  input logic                   clock,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 3) begin : g_bad_lus
    $error("LOAD_USE_STALLS must be in 1..3");
  end
  if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255) begin : g_bad_timeout
    $error("WAIT_TIMEOUT must be in 1..255");
  end
  if (STALL_CNT_W < 1) begin : g_bad_stall_cnt_w
    $error("STALL_CNT_W must be at least 1");
  end

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_LU_STALL = 2'd2;
  localparam logic [3:0] OP_LW       = 4'h1;
  localparam logic [3:0] OP_SW       = 4'h2;
  localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);
  // Bubbles still owed after the first one, which is issued from RUN.
  localparam logic [1:0] LU_EXTRA    = 2'(LOAD_USE_STALLS - 1);

  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

  // Register 0 is hard-wired, so it never carries a dependency.
  function automatic logic load_use_hit(input logic [3:0] ex_op,
                                        input logic [3:0] ex_rd,
                                        input logic [3:0] id_rs,
                                        input logic [3:0] id_rt);
    return (ex_op == OP_LW) && (ex_rd != 4'h0) &&
           ((ex_rd == id_rs) || (ex_rd == id_rt));
  endfunction

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [1:0] lu_cnt, lu_cnt_nxt;
  logic       mem_error_q, mem_error_nxt;
  logic       mem_op;
  logic       load_use;
  logic       freeze;
  logic       bubble;

  assign mem_op   = is_mem_op(bus.mem_instruction[19:16]);
  assign load_use = load_use_hit(bus.ex_instruction[19:16], bus.ex_instruction[15:12],
                                 bus.id_instruction[11:8],  bus.id_instruction[7:4]);

  // A memory freeze always takes priority over a bubble. In MEM_WAIT the
  // freeze persists until the memory answers or the wait budget runs out.
  assign freeze = ((state == ST_RUN || state == ST_LU_STALL) && mem_op && !bus.mem_ready) ||
                  ((state == ST_MEM_WAIT) && !bus.mem_ready && (wait_cnt < TIMEOUT_CNT));

  // The first unfrozen cycle after a wait re-checks the hazard, unless an
  // interrupted LU_STALL still has to finish its own bubbles.
  assign bubble = !freeze &&
                  (((state == ST_RUN) && load_use) ||
                   (state == ST_LU_STALL) ||
                   ((state == ST_MEM_WAIT) && (lu_cnt == 2'd0) && load_use));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_RUN;
      wait_cnt    <= 8'd0;
      lu_cnt      <= 2'd0;
      mem_error_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      lu_cnt      <= lu_cnt_nxt;
      mem_error_q <= mem_error_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    lu_cnt_nxt    = lu_cnt;
    mem_error_nxt = mem_error_q;
    case (state)
      ST_RUN: begin
        if (freeze) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else if (bubble && (LU_EXTRA != 2'd0)) begin
          state_nxt  = ST_LU_STALL;
          lu_cnt_nxt = LU_EXTRA;
        end
      end
      ST_LU_STALL: begin
        // The bubble count is held across a freeze and resumes afterwards.
        if (freeze) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else if (lu_cnt <= 2'd1) begin
          state_nxt  = ST_RUN;
          lu_cnt_nxt = 2'd0;
        end else begin
          lu_cnt_nxt = lu_cnt - 2'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          wait_cnt_nxt = 8'd0;
          // Released without ready means the wait budget expired.
          if (!bus.mem_ready) mem_error_nxt = 1'b1;
          if (lu_cnt != 2'd0) begin
            state_nxt = ST_LU_STALL;
          end else if (bubble && (LU_EXTRA != 2'd0)) begin
            state_nxt  = ST_LU_STALL;
            lu_cnt_nxt = LU_EXTRA;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 8'd0;
        lu_cnt_nxt   = 2'd0;
      end
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b1;
    bus.if_id_write   = 1'b1;
    bus.id_ex_write   = 1'b1;
    bus.id_ex_bubble  = 1'b0;
    bus.ex_mem_write  = 1'b1;
    bus.mem_wb_bubble = 1'b0;
    bus.mem_req       = 1'b0;
    if (reset) begin
      bus.mem_req = mem_op;
      if (freeze) begin
        bus.pc_write      = 1'b0;
        bus.if_id_write   = 1'b0;
        bus.id_ex_write   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.mem_wb_bubble = 1'b1;
      end else if (bubble) begin
        bus.pc_write     = 1'b0;
        bus.if_id_write  = 1'b0;
        bus.id_ex_bubble = 1'b1;
      end
    end
  end

  assign bus.ctrl_state = state;
  assign bus.mem_error  = mem_error_q;

`ifdef HAZARD_STALL_COUNT_EN
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STALL_CNT_W-1:0] stall_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (freeze || bubble) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif

  // The controller only looks at opcodes and register fields.
  logic unused_bits;
  assign unused_bits = ^{bus.id_instruction[19:12], bus.id_instruction[3:0],
                         bus.ex_instruction[11:0], bus.mem_instruction[15:0]};

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/bubble controller for the 5-stage, 20-bit pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards between the ID and EX stages and inserts bubbles.
- Sequences variable-latency data-memory accesses from the MEM stage with a req/ready handshake, freezing upstream stages and bubbling MEM/WB while it waits.
- Instantiated beside the pipeline registers in the processor top level.

Parameters:
- LOAD_USE_STALLS, 1, bubble cycles inserted per load-use hazard (legal 1..3).
- WAIT_TIMEOUT, 15, maximum MEM_WAIT cycles before forced release (legal 1..255).
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_instruction  in  20  instruction in the ID stage.
- ex_instruction  in  20  instruction in the EX stage (ID/EX output).
- mem_instruction  in  20  instruction in the MEM stage (EX/MEM output).
- mem_ready  in  1  data memory has completed the current access.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  load NOP (20'h00000) into ID/EX instead of ID data.
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- mem_req  out  1  data-memory access request.
- mem_error  out  1  sticky flag: a memory access timed out.
- ctrl_state  out  2  current FSM state.
- stall_cycles  out  STALL_CNT_W  stall counter (only with the optional feature).

Behaviour:
- Instruction fields:
  - [19:16] opcode, [15:12] rd, [11:8] rs, [7:4] rt.
  - LW = 4'h1, SW = 4'h2. All other opcodes are ALU or branch.
  - Register 0 never creates a hazard.
- Stall outputs are combinational from ctrl_state, the counters and the current inputs. State, counters and mem_error are registered.
- FSM states: RUN = 2'd0, MEM_WAIT = 2'd1, LU_STALL = 2'd2. Encoding 2'd3 is illegal and recovers to RUN on the next edge.
- Reset:
  - While reset = 0 at a rising edge: state becomes RUN, wait and stall counters become 0, mem_error becomes 0, stall_cycles becomes 0.
  - While reset is low, the outputs are forced: all *_write = 1, both bubbles = 0, mem_req = 0.
  - Reset asserted mid-wait or mid-stall aborts the sequence with no error.
- Defaults, unless a rule below overrides them: all *_write = 1, bubbles = 0, mem_req = 0.
- mem_req = 1 in any state whenever the mem_instruction opcode is LW or SW.
- Memory handshake (highest priority):
  - RUN, memory op, mem_ready = 1: zero-wait access, no stall.
  - RUN, memory op, mem_ready = 0:
    - Set pc_write = if_id_write = id_ex_write = ex_mem_write = 0 and mem_wb_bubble = 1.
    - Next state MEM_WAIT; wait counter becomes 1.
  - MEM_WAIT, mem_ready = 1: release this cycle (defaults apply); next state RUN.
  - MEM_WAIT, mem_ready = 0 and wait counter < WAIT_TIMEOUT: same freeze as above; wait counter increments.
  - MEM_WAIT, mem_ready = 0 and wait counter = WAIT_TIMEOUT: set mem_error; release as if ready; next state RUN.
  - mem_error stays set until reset.
- Load-use hazard, evaluated only when no memory freeze is active in that cycle:
  - Condition: ex opcode = LW, ex rd != 0, and (ex rd = id rs or ex rd = id rt).
  - Response: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
  - If LOAD_USE_STALLS > 1: enter LU_STALL with the remaining count set to LOAD_USE_STALLS-1.
  - LU_STALL: the same hold and bubble each cycle; the count decrements; return to RUN when it reaches 0.
  - If a memory freeze occurs during LU_STALL: the freeze pattern wins; id_ex_bubble = 0; the LU count is held; state moves to MEM_WAIT and returns to LU_STALL (not RUN) when the wait ends.
  - The lower-numbered rs/rt match is irrelevant; any match stalls.
- Simultaneous memory freeze and load-use condition: only the freeze applies. The hazard is re-evaluated in the first unfrozen cycle.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- Defined:
  - stall_cycles is present.
  - It increments by 1 on every cycle in which pc_write = 0.
  - It saturates at all-ones and clears on reset.
- Undefined: the stall_cycles port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Load-use: ex = 20'h13000 (LW r3), id = 20'h35340 (ADD r5,r3,r4), LOAD_USE_STALLS = 1 -> one cycle with pc_write = 0, if_id_write = 0, id_ex_bubble = 1; the next cycle is all defaults.
2. No hazard on r0 or a non-load: ex = 20'h10000 or ex = 20'h33000, id = 20'h35340 -> no stall.
3. Memory wait: mem = 20'h12000 (LW), mem_ready low for 3 cycles then high -> exactly 3 freeze cycles; mem_req high for 4 cycles; mem_error = 0.
4. Timeout, WAIT_TIMEOUT = 4: mem_ready held low -> 4 freeze cycles; forced release on cycle 5; mem_error = 1 and sticky.
5. Overlap, LOAD_USE_STALLS = 3, memory wait of 2 cycles during LU_STALL -> the freeze wins and the LU count is held; 3 bubbles in total; with HAZARD_STALL_COUNT_EN, stall_cycles = 5.
6. Reset low during MEM_WAIT -> next edge: ctrl_state = 0, mem_error = 0, outputs at their reset values.
